// File: rtl/writeback_arbiter.sv
// Result writeback arbiter: per-producer result FIFOs share NUM_BUS registered
// broadcast buses, granted round-robin starting from rr_ptr.
module writeback_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int NUM_BUS = 3,
    parameter int DEPTH   = 2,
    parameter int TAG_W   = 6,
    parameter int ROB_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*ROB_W-1:0]  src_rob,
    input  logic [NUM_SRC*DATA_W-1:0] src_value,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [NUM_BUS-1:0]        bus_valid,
    output logic [NUM_BUS*TAG_W-1:0]  bus_tag,
    output logic [NUM_BUS*ROB_W-1:0]  bus_rob,
    output logic [NUM_BUS*DATA_W-1:0] bus_value,
    output logic [NUM_BUS*2-1:0]      bus_src,
    output logic [NUM_SRC*2-1:0]      occupancy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int ENT_W = TAG_W + ROB_W + DATA_W;

    logic [NUM_SRC-1:0] empty;
    logic [ENT_W-1:0]   head [NUM_SRC];
    logic [NUM_SRC-1:0] grant;
    logic [SEL_W-1:0]   sel [NUM_BUS];
    logic [NUM_BUS-1:0] sel_valid;
    logic [SEL_W-1:0]   rr_ptr_reg;
    logic [SEL_W-1:0]   rr_next;
    logic [SEL_W-1:0]   idx;
    int                 n_granted;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic             push;

            // Ready looks only at the registered count, so a full FIFO never passes through.
            assign src_ready[gi]         = (count_reg < CNT_W'(DEPTH));
            assign push                  = src_valid[gi] & src_ready[gi];
            assign empty[gi]             = (count_reg == '0);
            assign head[gi]              = mem[rd_ptr_reg];
            assign occupancy[gi*2 +: 2]  = 2'(count_reg);

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= {src_tag[gi*TAG_W +: TAG_W],
                                        src_rob[gi*ROB_W +: ROB_W],
                                        src_value[gi*DATA_W +: DATA_W]};
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (grant[gi]) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    count_reg <= count_reg + CNT_W'(push) - CNT_W'(grant[gi]);
                end
            end
        end
    endgenerate

    // Walk sources from rr_ptr; the first NUM_BUS non-empty heads take buses 0,1,2 in order.
    always_comb begin
        grant     = '0;
        sel_valid = '0;
        n_granted = 0;
        idx       = '0;
        rr_next   = rr_ptr_reg;
        for (int b = 0; b < NUM_BUS; b++) sel[b] = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = SEL_W'((int'(rr_ptr_reg) + k) % NUM_SRC);
            if (!empty[idx] && n_granted < NUM_BUS) begin
                grant[idx] = 1'b1;
                for (int b = 0; b < NUM_BUS; b++) begin
                    if (n_granted == b) begin
                        sel[b]       = idx;
                        sel_valid[b] = 1'b1;
                    end
                end
                n_granted = n_granted + 1;
                rr_next   = SEL_W'((int'(idx) + 1) % NUM_SRC);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (|grant) begin
            rr_ptr_reg <= rr_next;
        end
    end

    generate
        for (gi = 0; gi < NUM_BUS; gi++) begin : g_bus
            logic             valid_reg;
            logic [ENT_W-1:0] ent_reg;
            logic [SEL_W-1:0] src_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    ent_reg   <= '0;
                    src_reg   <= '0;
                end else if (sel_valid[gi]) begin
                    valid_reg <= 1'b1;
                    ent_reg   <= head[sel[gi]];
                    src_reg   <= sel[gi];
                end else begin
                    valid_reg <= 1'b0;
                    ent_reg   <= '0;
                    src_reg   <= '0;
                end
            end

            assign bus_valid[gi]                = valid_reg;
            assign bus_tag[gi*TAG_W +: TAG_W]   = ent_reg[ENT_W-1 -: TAG_W];
            assign bus_rob[gi*ROB_W +: ROB_W]   = ent_reg[DATA_W +: ROB_W];
            assign bus_value[gi*DATA_W +: DATA_W] = ent_reg[DATA_W-1:0];
            assign bus_src[gi*2 +: 2]           = 2'(src_reg);
        end
    endgenerate
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: hand-computed bus contents, ready
// pattern under saturation, per-source ordering and reset discard.
module tb_writeback_arbiter;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   src_valid = '0;
    logic [23:0]  src_tag = '0;
    logic [23:0]  src_rob = '0;
    logic [127:0] src_value = '0;
    logic [3:0]   src_ready;
    logic [2:0]   bus_valid;
    logic [17:0]  bus_tag;
    logic [17:0]  bus_rob;
    logic [95:0]  bus_value;
    logic [5:0]   bus_src;
    logic [7:0]   occupancy;

    int vectors = 0;
    int miscompares = 0;

    writeback_arbiter dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_tag(src_tag), .src_rob(src_rob), .src_value(src_value),
        .src_ready(src_ready),
        .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_rob(bus_rob), .bus_value(bus_value),
        .bus_src(bus_src), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [5:0] t, input logic [5:0] r, input logic [31:0] v);
        src_tag[i*6 +: 6]    = t;
        src_rob[i*6 +: 6]    = r;
        src_value[i*32 +: 32] = v;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] bval(input int b);
        return bus_value[b*32 +: 32];
    endfunction
    function automatic logic [5:0] btag(input int b);
        return bus_tag[b*6 +: 6];
    endfunction
    function automatic logic [5:0] brob(input int b);
        return bus_rob[b*6 +: 6];
    endfunction
    function automatic logic [1:0] bsrc(input int b);
        return bus_src[b*2 +: 2];
    endfunction

    initial begin
        int sent [4];
        int rcvd [4];
        int grants [4];
        logic [3:0] hs;
        logic [3:0] ready_tbl [4];
        int s;

        ready_tbl[0] = 4'b0111;
        ready_tbl[1] = 4'b1011;
        ready_tbl[2] = 4'b1101;
        ready_tbl[3] = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0; rcvd[i] = 0; grants[i] = 0;
        end

        // Reset state
        #1;
        chk("rst_bus_valid", bus_valid, 3'b000);
        chk("rst_src_ready", src_ready, 4'b1111);
        chk("rst_occupancy", occupancy, 8'h00);
        chk("rst_bus_value", bus_value, 96'h0);
        tick();
        tick();
        reset = 1'b0;
        chk("post_rst_ready", src_ready, 4'b1111);

        // T1: single result, two-edge latency, one cycle on the bus
        set_src(0, 6'd5, 6'd3, 32'h1234);
        src_valid = 4'b0001;
        tick();
        src_valid = 4'b0000;
        chk("t1_occ_e1", occupancy, 8'h01);
        chk("t1_valid_e1", bus_valid, 3'b000);
        tick();
        chk("t1_valid_e2", bus_valid, 3'b001);
        chk("t1_tag", btag(0), 6'd5);
        chk("t1_rob", brob(0), 6'd3);
        chk("t1_value", bval(0), 32'h1234);
        chk("t1_src", bsrc(0), 2'd0);
        chk("t1_occ_e2", occupancy, 8'h00);
        tick();
        chk("t1_valid_e3", bus_valid, 3'b000);

        // T2: all four push with rr_ptr=0
        reset_dut();
        for (int i = 0; i < 4; i++) set_src(i, 6'(10 + i), 6'(20 + i), 32'(32'h100 + i));
        src_valid = 4'b1111;
        tick();
        src_valid = 4'b0000;
        chk("t2_occ_e1", occupancy, 8'h55);
        tick();
        chk("t2_valid_e2", bus_valid, 3'b111);
        chk("t2_src_e2", bus_src, 6'h24);
        chk("t2_val0", bval(0), 32'h100);
        chk("t2_val1", bval(1), 32'h101);
        chk("t2_val2", bval(2), 32'h102);
        chk("t2_tag2", btag(2), 6'd12);
        chk("t2_occ_e2", occupancy, 8'h40);
        tick();
        chk("t2_valid_e3", bus_valid, 3'b001);
        chk("t2_src_e3", bsrc(0), 2'd3);
        chk("t2_val_e3", bval(0), 32'h103);
        chk("t2_rob_e3", brob(0), 6'd23);
        chk("t2_occ_e3", occupancy, 8'h00);
        tick();
        chk("t2_valid_e4", bus_valid, 3'b000);

        // T4: push on the same edge src2 is popped
        set_src(2, 6'd7, 6'd9, 32'hA);
        src_valid = 4'b0100;
        tick();
        set_src(2, 6'd8, 6'd9, 32'hB);
        tick();
        src_valid = 4'b0000;
        chk("t4_occ", occupancy, 8'h10);
        chk("t4_valid_a", bus_valid, 3'b001);
        chk("t4_src_a", bsrc(0), 2'd2);
        chk("t4_val_a", bval(0), 32'hA);
        tick();
        chk("t4_valid_b", bus_valid, 3'b001);
        chk("t4_val_b", bval(0), 32'hB);
        chk("t4_occ_b", occupancy, 8'h00);
        tick();
        chk("t4_valid_c", bus_valid, 3'b000);

        // T3/T5: saturate all producers for 20 edges, then drain
        reset_dut();
        for (int j = 1; j <= 30; j++) begin
            if (j <= 20) begin
                for (int i = 0; i < 4; i++)
                    set_src(i, 6'(sent[i] + 1), 6'(i), 32'((i << 16) | sent[i]));
                src_valid = 4'b1111;
            end else begin
                src_valid = 4'b0000;
            end
            hs = src_valid & src_ready;
            tick();
            for (int i = 0; i < 4; i++) if (hs[i]) sent[i]++;
            if (j >= 2 && j <= 20) begin
                chk($sformatf("t3_ready_c%0d", j), src_ready, ready_tbl[(j - 2) % 4]);
                chk($sformatf("t3_busy_c%0d", j), bus_valid, 3'b111);
            end
            if (j == 4) chk("t5_src1_full", occupancy[3:2], 2'd2);
            if (j == 6) chk("t5_src1_taken", sent[1], 5);
            for (int b = 0; b < 3; b++) begin
                if (bus_valid[b]) begin
                    s = int'(bsrc(b));
                    chk($sformatf("t3_beat_val_c%0d_b%0d", j, b), bval(b), 32'((s << 16) | rcvd[s]));
                    chk($sformatf("t3_beat_tag_c%0d_b%0d", j, b), btag(b), 6'(rcvd[s] + 1));
                    rcvd[s]++;
                    if (j >= 2 && j <= 21) grants[s]++;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_fair_src%0d", i), (grants[i] >= 14 && grants[i] <= 16), 1'b1);
            chk($sformatf("t3_count_src%0d", i), rcvd[i], sent[i]);
        end
        chk("t3_drained_occ", occupancy, 8'h00);
        chk("t3_drained_valid", bus_valid, 3'b000);

        // T6: asynchronous reset with five entries queued
        reset_dut();
        for (int i = 0; i < 4; i++) set_src(i, 6'(40 + i), 6'(i), 32'(32'h500 + i));
        src_valid = 4'b1111;
        tick();
        tick();
        src_valid = 4'b0000;
        chk("t6_occ_queued", occupancy, 8'h95);
        chk("t6_valid_queued", bus_valid, 3'b111);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_valid_rst", bus_valid, 3'b000);
        chk("t6_ready_rst", src_ready, 4'b1111);
        chk("t6_occ_rst", occupancy, 8'h00);
        chk("t6_value_rst", bus_value, 96'h0);
        tick();
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk($sformatf("t6_quiet_valid_c%0d", j), bus_valid, 3'b000);
            chk($sformatf("t6_quiet_occ_c%0d", j), occupancy, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
